conv_param_store: RTL and testbench
===================================

# conv_param_store

Parametrised convolution parameter store for the CNN inference core: it takes the serial byte stream from the host loader and writes it into one weight RAM and one bias RAM, packing the bias bytes into words as they arrive. Once loading finishes, it serves per-layer, offset-addressed reads to the conv engines. It replaces the fixed-size weight/bias RAM pair and adds a sequencer, per-layer base translation, status flags and overflow detection.

## Interface
- `W_WIDTH`, 8: weight word width in bits (signed int8).
- `B_WIDTH`, 32: bias word width in bits; must be a multiple of 8.
- `W_L1_SIZE`, 144: layer-1 weight count.
- `W_L2_SIZE`, 4608: layer-2 weight count.
- `B_L1_COUNT`, 16: layer-1 bias count.
- `B_L2_COUNT`, 32: layer-2 bias count.
- Derived: `W_DEPTH = W_L1_SIZE + W_L2_SIZE`, `B_DEPTH = B_L1_COUNT + B_L2_COUNT`.
  - `WA = $clog2(W_DEPTH)`, `BA = $clog2(B_DEPTH)`, `BPW = B_WIDTH/8`.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `load_start`, in, 1: one-cycle pulse that begins or restarts a load.
- `in_valid`, in, 1: byte strobe from the host loader.
- `in_data`, in, 8: stream byte.
- `in_ready`, out, 1: high only in LOAD_W or LOAD_B.
- `loaded`, out, 1: high once the full image has been written.
- `overflow`, out, 1: sticky; set when a byte arrives while not ready.
- `w_rd_en`, in, 1: weight read request.
- `w_rd_layer`, in, 1: layer select, 0 = L1, 1 = L2.
- `w_rd_off`, in, WA: weight offset within the selected layer.
- `w_rd_data`, out, W_WIDTH: weight read data.
- `w_rd_valid`, out, 1: weight read data valid.
- `b_rd_en`, in, 1: bias read request.
- `b_rd_layer`, in, 1: layer select, 0 = L1, 1 = L2.
- `b_rd_off`, in, BA: bias offset within the selected layer.
- `b_rd_data`, out, B_WIDTH: bias read data.
- `b_rd_valid`, out, 1: bias read data valid.

## Operation
- States:
  - IDLE → (`load_start`) → LOAD_W.
  - LOAD_W → (last weight byte accepted) → LOAD_B.
  - LOAD_B → (last bias word committed) → DONE.
  - DONE → (`load_start`) → LOAD_W.
- Every state: `load_start` clears `wptr`, `bptr`, `byte_idx`, `loaded` and `overflow`, then enters LOAD_W. This includes a restart mid-load; RAM contents are not cleared.
- LOAD_W: each `in_valid` byte is written to `wram[wptr]`, then `wptr` increments. When `wptr == W_DEPTH-1` is accepted, go to LOAD_B.
- LOAD_B: bytes are packed little-endian.
  - Byte `k` (`byte_idx`, 0..BPW-1) goes to bits `[8k+7:8k]` of the shift register.
  - On `byte_idx == BPW-1` the assembled word is written to `bram[bptr]`; `bptr` increments and `byte_idx` returns to 0.
  - When the last word is committed: go to DONE and set `loaded`.
- `in_valid` in IDLE or DONE: byte dropped, `overflow` set. `in_valid` together with `load_start`: the `load_start` wins and the byte is dropped, but `overflow` is not set.
- Read address translation:
  - Weights: `layer ? W_L1_SIZE + off : off`.
  - Biases: `layer ? B_L1_COUNT + off : off`.
  - Offsets are not range-checked. A translated address ≥ depth returns don't-care data; `*_valid` still asserts.
- Reads are allowed in every state. Reads during a load return the current RAM contents.
- Same-cycle read and write to the same address returns the old data (read-first).

## Timing
- Reset values: `in_ready=0`, `loaded=0`, `overflow=0`, `w_rd_valid=0`, `b_rd_valid=0`, `w_rd_data=0`, `b_rd_data=0`; state IDLE; all counters 0.
- `in_ready` is registered from the state. A byte is accepted in the cycle `in_valid && in_ready`; no backpressure inside a load.
- `loaded` rises in the cycle after the final bias byte is accepted.
- Minimum load time: `W_DEPTH + BPW·B_DEPTH` accepted bytes (4944 with the defaults).
- Read latency is 1 cycle: `*_rd_valid` is registered `*_rd_en`, and data is held when `en=0`. Back-to-back reads give one result per cycle.
- Weight RAM is block RAM; bias RAM is distributed. Both have synchronous write and synchronous read.

## Structure
- Shared package `cnn_pkg`: `W_WIDTH`, `B_WIDTH`, the layer size constants and the state encoding (IDLE/LOAD_W/LOAD_B/DONE).
- One sub-module, `sp_ram_1r1w #(DW, DEPTH, STYLE)`: a generic synchronous RAM instantiated twice, with STYLE driving the `ram_style` attribute.
- The sequencer and address translation live in the top module.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles → all outputs 0, `in_ready=0`.
- **Full load:**
  - Stimulus: pulse `load_start`, stream weights `i&0xFF`, then biases where bias `j` is `0x00010000+j`, LE bytes.
  - `loaded` goes high exactly after byte 4944.
  - Reading L2 weight offset 0 → `0x90`.
  - Reading L2 bias offset 5 (`bram[21]`) → `0x00010015`.
- **Read latency:** `w_rd_en` on consecutive cycles with offsets 0,1,2 on L1 → data 0x00,0x01,0x02 on the following cycles, with `w_rd_valid` high for 3 cycles.
- **Overflow:** after `loaded`, send 1 byte → `overflow=1`, RAM unchanged, and `overflow` stays high until `load_start`.
- **Mid-load restart:**
  - Stimulus: after 100 weight bytes pulse `load_start`, then send a full image with all bytes `0x55`.
  - `wram[0..99]` reads `0x55`; `loaded` goes high after 4944 bytes counted from the restart.
- **Bias packing across a gap:** in LOAD_B, send 2 bytes, idle 10 cycles, then send 2 bytes → one word is committed only on the 4th byte, `bptr` advances by 1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and load-sequencer state encoding for the CNN inference core.
package cnn_pkg;

  localparam int unsigned W_WIDTH    = 8;
  localparam int unsigned B_WIDTH    = 32;
  localparam int unsigned W_L1_SIZE  = 144;
  localparam int unsigned W_L2_SIZE  = 4608;
  localparam int unsigned B_L1_COUNT = 16;
  localparam int unsigned B_L2_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/sp_ram_1r1w.sv
// Generic single-write, single-read synchronous RAM; read-first, output held when not reading.
module sp_ram_1r1w #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter string       STYLE = "block",
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o
);

  logic [DW-1:0] mem_rd;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;

  generate
    if (STYLE == "distributed") begin : g_dist
      (* ram_style = "distributed" *) logic [DW-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
      end
      assign mem_rd = mem[raddr_i];
    end else begin : g_block
      (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
      end
      assign mem_rd = mem[raddr_i];
    end
  endgenerate

  // Output register samples the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= re_i;
      if (re_i) rdata_q <= mem_rd;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/conv_param_store.sv
// Convolution parameter store: loads weights and packed biases from a byte stream,
// then serves per-layer offset-addressed reads.
module conv_param_store #(
  parameter int unsigned  W_WIDTH    = cnn_pkg::W_WIDTH,
  parameter int unsigned  B_WIDTH    = cnn_pkg::B_WIDTH,
  parameter int unsigned  W_L1_SIZE  = cnn_pkg::W_L1_SIZE,
  parameter int unsigned  W_L2_SIZE  = cnn_pkg::W_L2_SIZE,
  parameter int unsigned  B_L1_COUNT = cnn_pkg::B_L1_COUNT,
  parameter int unsigned  B_L2_COUNT = cnn_pkg::B_L2_COUNT,
  localparam int unsigned W_DEPTH    = W_L1_SIZE + W_L2_SIZE,
  localparam int unsigned B_DEPTH    = B_L1_COUNT + B_L2_COUNT,
  localparam int unsigned WA         = $clog2(W_DEPTH),
  localparam int unsigned BA         = $clog2(B_DEPTH),
  localparam int unsigned BPW        = B_WIDTH / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               loaded,
  output logic               overflow,
  input  logic               w_rd_en,
  input  logic               w_rd_layer,
  input  logic [WA-1:0]      w_rd_off,
  output logic [W_WIDTH-1:0] w_rd_data,
  output logic               w_rd_valid,
  input  logic               b_rd_en,
  input  logic               b_rd_layer,
  input  logic [BA-1:0]      b_rd_off,
  output logic [B_WIDTH-1:0] b_rd_data,
  output logic               b_rd_valid
);

  import cnn_pkg::*;

  localparam int unsigned BIW = (BPW > 1) ? $clog2(BPW) : 1;

  state_e             state_q;
  logic [WA-1:0]      wptr_q;
  logic [BA-1:0]      bptr_q;
  logic [BIW-1:0]     byte_idx_q;
  logic [B_WIDTH-1:0] shift_q;
  logic               in_ready_q;
  logic               loaded_q;
  logic               overflow_q;

  logic               accept;
  logic               w_we;
  logic               b_we;
  logic [B_WIDTH-1:0] b_word;
  logic [WA-1:0]      w_raddr;
  logic [BA-1:0]      b_raddr;

  // Byte acceptance, RAM write strobes and little-endian bias word assembly.
  always_comb begin
    accept = in_valid && in_ready_q && !load_start;
    w_we   = accept && (state_q == LOAD_W);
    b_we   = accept && (state_q == LOAD_B) && (byte_idx_q == BIW'(BPW - 1));
    b_word = shift_q;
    for (int unsigned k = 0; k < BPW; k++) begin
      if (byte_idx_q == BIW'(k)) b_word[8*k +: 8] = in_data;
    end
  end

  assign w_raddr = w_rd_layer ? (WA'(W_L1_SIZE) + w_rd_off) : w_rd_off;
  assign b_raddr = b_rd_layer ? (BA'(B_L1_COUNT) + b_rd_off) : b_rd_off;

  // Load sequencer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      bptr_q     <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      in_ready_q <= 1'b0;
      loaded_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (load_start) begin
      state_q    <= LOAD_W;
      wptr_q     <= '0;
      bptr_q     <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      in_ready_q <= 1'b1;
      loaded_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (in_valid && !in_ready_q) overflow_q <= 1'b1;
      case (state_q)
        LOAD_W: begin
          if (accept) begin
            wptr_q <= wptr_q + WA'(1);
            if (wptr_q == WA'(W_DEPTH - 1)) state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept) begin
            shift_q <= b_word;
            if (byte_idx_q == BIW'(BPW - 1)) begin
              byte_idx_q <= '0;
              bptr_q     <= bptr_q + BA'(1);
              if (bptr_q == BA'(B_DEPTH - 1)) begin
                state_q    <= DONE;
                in_ready_q <= 1'b0;
                loaded_q   <= 1'b1;
              end
            end else begin
              byte_idx_q <= byte_idx_q + BIW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign loaded   = loaded_q;
  assign overflow = overflow_q;

  sp_ram_1r1w #(
    .DW   (W_WIDTH),
    .DEPTH(W_DEPTH),
    .STYLE("block")
  ) u_wram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (w_we),
    .waddr_i (wptr_q),
    .wdata_i (W_WIDTH'(in_data)),
    .re_i    (w_rd_en),
    .raddr_i (w_raddr),
    .rdata_o (w_rd_data),
    .rvalid_o(w_rd_valid)
  );

  sp_ram_1r1w #(
    .DW   (B_WIDTH),
    .DEPTH(B_DEPTH),
    .STYLE("distributed")
  ) u_bram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (b_we),
    .waddr_i (bptr_q),
    .wdata_i (b_word),
    .re_i    (b_rd_en),
    .raddr_i (b_raddr),
    .rdata_o (b_rd_data),
    .rvalid_o(b_rd_valid)
  );

endmodule

// File: tb/tb_conv_param_store.sv
// Self-checking bench for conv_param_store: vector table, directed load/read sequences
// and randomized traffic against a byte-count image model.
module tb_conv_param_store;

  localparam int W_L1    = 144;
  localparam int W_DEPTH = 4752;
  localparam int B_L1    = 16;
  localparam int B_DEPTH = 48;
  localparam int BPW     = 4;
  localparam int TOTAL   = W_DEPTH + BPW * B_DEPTH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, loaded, overflow;
  logic        w_rd_en, w_rd_layer;
  logic [12:0] w_rd_off;
  logic [7:0]  w_rd_data;
  logic        w_rd_valid;
  logic        b_rd_en, b_rd_layer;
  logic [5:0]  b_rd_off;
  logic [31:0] b_rd_data;
  logic        b_rd_valid;

  always #5 clk = ~clk;

  conv_param_store dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .loaded(loaded), .overflow(overflow),
    .w_rd_en(w_rd_en), .w_rd_layer(w_rd_layer), .w_rd_off(w_rd_off),
    .w_rd_data(w_rd_data), .w_rd_valid(w_rd_valid),
    .b_rd_en(b_rd_en), .b_rd_layer(b_rd_layer), .b_rd_off(b_rd_off),
    .b_rd_data(b_rd_data), .b_rd_valid(b_rd_valid)
  );

  // Reference model: expected RAM images plus a count of bytes accepted since load_start.
  logic [7:0]  wm [W_DEPTH];
  logic [31:0] bm [B_DEPTH];
  logic [31:0] pend;
  int          nbytes;
  bit          loading, m_loaded, m_ovf, m_wv, m_bv;
  logic [7:0]  m_wd;
  logic [31:0] m_bd;
  bit          rd_ok;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit ls, input bit iv, input logic [7:0] d,
                     input bit wen, input bit wl, input logic [12:0] woff,
                     input bit ben, input bit bl, input logic [5:0] boff);
    int a, m;
    load_start = ls; in_valid = iv; in_data = d;
    w_rd_en = wen; w_rd_layer = wl; w_rd_off = woff;
    b_rd_en = ben; b_rd_layer = bl; b_rd_off = boff;
    @(posedge clk);
    m_wv = wen;
    if (wen) begin
      a = wl ? W_L1 + int'(woff) : int'(woff);
      m_wd = wm[a];
    end
    m_bv = ben;
    if (ben) begin
      a = bl ? B_L1 + int'(boff) : int'(boff);
      m_bd = bm[a];
    end
    if (ls) begin
      nbytes = 0; loading = 1; m_loaded = 0; m_ovf = 0;
    end else if (iv) begin
      if (!loading) m_ovf = 1;
      else begin
        if (nbytes < W_DEPTH) wm[nbytes] = d;
        else begin
          m = nbytes - W_DEPTH;
          pend[8*(m%BPW) +: 8] = d;
          if (m % BPW == BPW - 1) bm[m/BPW] = pend;
        end
        nbytes++;
        if (nbytes == TOTAL) begin loading = 0; m_loaded = 1; end
      end
    end
    #1;
    chk("in_ready", in_ready, loading);
    chk("loaded", loaded, m_loaded);
    chk("overflow", overflow, m_ovf);
    chk("w_rd_valid", w_rd_valid, m_wv);
    chk("b_rd_valid", b_rd_valid, m_bv);
    chk("w_rd_data", w_rd_data, m_wd);
    chk("b_rd_data", b_rd_data, m_bd);
  endtask

  // One cycle with randomized in-range reads when the RAM image is fully known.
  task automatic rcyc(input bit ls, input bit iv, input logic [7:0] d);
    bit wen, wl, ben, bl;
    logic [12:0] woff;
    logic [5:0] boff;
    wen = rd_ok && ($urandom_range(0, 1) == 1);
    ben = rd_ok && ($urandom_range(0, 1) == 1);
    wl = 1'($urandom_range(0, 1));
    bl = 1'($urandom_range(0, 1));
    woff = 13'(wl ? $urandom_range(0, W_DEPTH - W_L1 - 1) : $urandom_range(0, W_L1 - 1));
    boff = 6'(bl ? $urandom_range(0, B_DEPTH - B_L1 - 1) : $urandom_range(0, B_L1 - 1));
    cyc(ls, iv, d, wen, wl, woff, ben, bl, boff);
  endtask

  function automatic logic [7:0] pat_byte(input int i);
    int m;
    logic [31:0] w;
    if (i < W_DEPTH) return 8'(i & 8'hFF);
    m = i - W_DEPTH;
    w = 32'h0001_0000 + 32'(m / BPW);
    return w[8*(m%BPW) +: 8];
  endfunction

  // mode 0: all 0x55, mode 1: index pattern; checks loaded rises exactly on the last byte.
  task automatic load_image(input int mode);
    rcyc(1, 0, 8'h00);
    for (int i = 0; i < TOTAL; i++) begin
      rcyc(0, 1, (mode == 0) ? 8'h55 : pat_byte(i));
      if (i == TOTAL - 2) chk("loaded_early", loaded, 0);
      if (i == TOTAL - 1) chk("loaded_on_last", loaded, 1);
    end
  endtask

  typedef struct {
    bit ls; bit iv; logic [7:0] d; bit rdy; bit ld; bit ov;
  } vec_t;
  vec_t tbl [6];

  logic [7:0] gb [4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{ls:0, iv:0, d:8'h00, rdy:0, ld:0, ov:0};
    tbl[1] = '{ls:0, iv:1, d:8'h11, rdy:0, ld:0, ov:1};
    tbl[2] = '{ls:0, iv:0, d:8'h00, rdy:0, ld:0, ov:1};
    tbl[3] = '{ls:1, iv:1, d:8'h22, rdy:1, ld:0, ov:0};
    tbl[4] = '{ls:0, iv:1, d:8'hA0, rdy:1, ld:0, ov:0};
    tbl[5] = '{ls:0, iv:0, d:8'h00, rdy:1, ld:0, ov:0};

    rst_n = 1'b0; load_start = 0; in_valid = 0; in_data = 0;
    w_rd_en = 0; w_rd_layer = 0; w_rd_off = 0;
    b_rd_en = 0; b_rd_layer = 0; b_rd_off = 0;
    nbytes = 0; loading = 0; m_loaded = 0; m_ovf = 0;
    m_wv = 0; m_bv = 0; m_wd = 0; m_bd = 0; pend = 0; rd_ok = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_w_valid", w_rd_valid, 0);
    chk("rst_b_valid", b_rd_valid, 0);
    chk("rst_w_data", w_rd_data, 0);
    chk("rst_b_data", b_rd_data, 0);
    rst_n = 1'b1;

    // Idle overflow, sticky flag, load_start beating a same-cycle byte.
    foreach (tbl[i]) begin
      cyc(tbl[i].ls, tbl[i].iv, tbl[i].d, 0, 0, 0, 0, 0, 0);
      chk("tbl_ready", in_ready, tbl[i].rdy);
      chk("tbl_loaded", loaded, tbl[i].ld);
      chk("tbl_overflow", overflow, tbl[i].ov);
    end

    // Mid-load restart after 100 weight bytes, then a full 0x55 image.
    for (int i = 1; i < 100; i++) rcyc(0, 1, 8'($urandom));
    load_image(0);
    rd_ok = 1;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 0, 0, 1, 0, 13'(i), 0, 0, 0);
      chk("restart_w55", w_rd_data, 8'h55);
    end

    // Full patterned load.
    load_image(1);
    cyc(0, 0, 0, 1, 1, 13'd0, 1, 1, 6'd5);
    chk("w_l2_off0", w_rd_data, 8'h90);
    chk("b_l2_off5", b_rd_data, 32'h0001_0015);

    // Back-to-back reads, one result per cycle.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 13'(i), 0, 0, 0);
      chk("b2b_valid", w_rd_valid, 1);
      chk("b2b_data", w_rd_data, 8'(i));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_valid_drop", w_rd_valid, 0);
    chk("b2b_hold", w_rd_data, 8'h02);

    // Overflow after loaded: byte dropped, flag sticky until load_start.
    cyc(0, 1, 8'hEE, 0, 0, 0, 0, 0, 0);
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0, 13'd0, 1, 0, 6'd0);
      chk("ovf_sticky", overflow, 1);
    end
    chk("ovf_w0_unchanged", w_rd_data, 8'h00);
    chk("ovf_b0_unchanged", b_rd_data, 32'h0001_0000);

    // Bias packing across an idle gap.
    rcyc(1, 0, 8'h00);
    chk("restart_ovf_clr", overflow, 0);
    for (int i = 0; i < W_DEPTH; i++) rcyc(0, 1, 8'($urandom));
    foreach (gb[i]) gb[i] = 8'($urandom);
    cyc(0, 1, gb[0], 0, 0, 0, 0, 0, 0);
    cyc(0, 1, gb[1], 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 6'd0);
    chk("gap_b0_old", b_rd_data, 32'h0001_0000);
    cyc(0, 1, gb[2], 0, 0, 0, 1, 0, 6'd0);
    cyc(0, 1, gb[3], 0, 0, 0, 1, 0, 6'd0);
    chk("gap_read_first", b_rd_data, 32'h0001_0000);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 6'd0);
    chk("gap_b0_new", b_rd_data, {gb[3], gb[2], gb[1], gb[0]});
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 6'd1);
    chk("gap_b1_untouched", b_rd_data, 32'h0001_0001);

    // Randomized traffic, rare restarts, reads in every phase.
    for (int i = 0; i < 6000; i++)
      rcyc(($urandom_range(0, 2999) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
